// File: rtl/accum_requant.sv
// Accumulates a group of signed partial results, then requantizes the sum to OUT_WIDTH with saturation.
// Build option: define ACCUM_REQUANT_ROUND_EN for round-half-up instead of truncation toward minus infinity.
module accum_requant #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IN_WIDTH-1:0]  D_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [CNT_WIDTH-1:0] num_acc,
  input  logic [5:0]           shift,
  output logic [OUT_WIDTH-1:0] Q_out,
  output logic                 sat_o,
  output logic                 valid_out,
  input  logic                 ready_out
);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Saturation bounds, widened to the requant datapath so the compare sees every bit.
  localparam logic signed [ACC_WIDTH:0] OUT_MAX_W =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN_W =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        num_q, num_d;
  logic [5:0]                  shift_q, shift_d;
  logic [OUT_WIDTH-1:0]        q_q, q_d;
  logic                        sat_q, sat_d;

  logic                        beat;
  logic                        first;
  logic                        last;
  logic [CNT_WIDTH-1:0]        num_eff;
  logic [CNT_WIDTH-1:0]        grp_num;
  logic [5:0]                  grp_shift;
  logic [5:0]                  sh_eff;
  logic signed [ACC_WIDTH-1:0] d_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH:0]   sum_w;
  logic signed [ACC_WIDTH:0]   rounded;
  logic signed [ACC_WIDTH:0]   shifted;
  logic                        too_hi;
  logic                        too_lo;
  logic [OUT_WIDTH-1:0]        q_sat;

  assign ready_in  = (state_q == S_ACC) && !rst_i;
  assign beat      = valid_in && ready_in;
  assign first     = (cnt_q == '0);

  // The group length and shift come straight from the ports on the first beat, from the latches afterwards.
  assign num_eff   = (num_acc == '0) ? CNT_WIDTH'(1) : num_acc;
  assign grp_num   = first ? num_eff : num_q;
  assign grp_shift = first ? shift : shift_q;
  assign last      = (cnt_q == grp_num - CNT_WIDTH'(1));

  assign d_ext     = ACC_WIDTH'($signed(D_in));
  assign sum       = acc_q + d_ext;

  assign sh_eff    = (int'(grp_shift) > ACC_WIDTH - 1) ? 6'(ACC_WIDTH - 1) : grp_shift;
  // One extra bit keeps the rounding increment from wrapping a near-full-scale sum.
  assign sum_w     = (ACC_WIDTH + 1)'(sum);

`ifdef ACCUM_REQUANT_ROUND_EN
  logic [ACC_WIDTH:0] rnd;
  assign rnd       = ((ACC_WIDTH + 1)'(1) << sh_eff) >> 1;
  assign rounded   = sum_w + $signed(rnd);
`else
  assign rounded   = sum_w;
`endif

  assign shifted   = rounded >>> sh_eff;
  assign too_hi    = shifted > OUT_MAX_W;
  assign too_lo    = shifted < OUT_MIN_W;
  assign q_sat     = too_hi ? OUT_MAX :
                     too_lo ? OUT_MIN : shifted[OUT_WIDTH-1:0];

  // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    shift_d = shift_q;
    q_d     = q_q;
    sat_d   = sat_q;
    case (state_q)
      S_ACC: begin
        if (beat) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (first) begin
            num_d   = num_eff;
            shift_d = shift;
          end
          if (last) begin
            q_d     = q_sat;
            sat_d   = too_hi || too_lo;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (ready_out) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      shift_q <= '0;
      q_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      shift_q <= shift_d;
      q_q     <= q_d;
      sat_q   <= sat_d;
    end
  end

  assign Q_out     = q_q;
  assign sat_o     = sat_q;
  assign valid_out = (state_q == S_HOLD);

endmodule

// File: tb/tb_accum_requant.sv
// Scoreboard bench for accum_requant: expected results are queued at stimulus time, popped on each output transfer.
module tb_accum_requant;

  typedef struct {
    logic [7:0] q;
    logic       sat;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] D_in;
  logic        valid_in;
  logic        ready_in;
  logic [7:0]  num_acc;
  logic [5:0]  shift;
  logic [7:0]  Q_out;
  logic        sat_o;
  logic        valid_out;
  logic        ready_out;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];

  accum_requant dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .D_in      (D_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .num_acc   (num_acc),
    .shift     (shift),
    .Q_out     (Q_out),
    .sat_o     (sat_o),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Independent reference for requant at default parameters.
  function automatic exp_t ref_requant(input longint s, input int sh);
    exp_t   e;
    longint v = s;
    if (sh > 39) sh = 39;
`ifdef ACCUM_REQUANT_ROUND_EN
    if (sh > 0) v = v + (64'sd1 <<< (sh - 1));
`endif
    v = v >>> sh;
    if (v > 127) begin
      e.q = 8'd127; e.sat = 1'b1;
    end else if (v < -128) begin
      e.q = 8'h80; e.sat = 1'b1;
    end else begin
      e.q = 8'(v); e.sat = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t mk(input int q, input logic sat);
    exp_t e;
    e.q   = 8'(q);
    e.sat = sat;
    return e;
  endfunction

  // Every accepted output transfer is matched against the oldest queued expectation.
  always @(negedge clk_i) begin
    if (!rst_i && valid_out && ready_out) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got Q_out=%0d sat_o=%0b, no result expected",
                 $signed(Q_out), sat_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Q_out !== e.q || sat_o !== e.sat) begin
          n_fail++;
          $display("FAIL output: got Q_out=%0d sat_o=%0b, expected Q_out=%0d sat_o=%0b",
                   $signed(Q_out), sat_o, $signed(e.q), e.sat);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the beat is taken.
  task automatic send(input int d);
    int guard = 0;
    valid_in = 1'b1;
    D_in     = 32'(d);
    @(negedge clk_i);
    while (!ready_in && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: ready_in=%0b, required 1 within 50 cycles", ready_in);
    end
    @(posedge clk_i);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while ((sb.size() != 0 || valid_out) && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    n_tests++;
    if (sb.size() != 0 || valid_out) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results pending, required 0", name, sb.size());
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (ready_in !== 1'b0 || valid_out !== 1'b0 || Q_out !== 8'd0 || sat_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready_in=%0b valid_out=%0b Q_out=%0d sat_o=%0b, required 0 0 0 0",
               ready_in, valid_out, Q_out, sat_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (ready_in !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: ready_in=%0b, required 1", ready_in);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_group_sum();
    int vals[4] = '{10, 20, 30, 40};
    num_acc = 8'd4;
    shift   = 6'd2;
    sb.push_back(mk(25, 1'b0));
    for (int i = 0; i < 4; i++) begin
      send(vals[i]);
      n_tests++;
      if (valid_out !== (i == 3)) begin
        n_fail++;
        $display("FAIL group_latency: after beat %0d valid_out=%0b, required %0b",
                 i + 1, valid_out, (i == 3));
      end
    end
    wait_drain("group_sum");
  endtask

  task automatic test_rounding();
    num_acc = 8'd1;
    shift   = 6'd2;
`ifdef ACCUM_REQUANT_ROUND_EN
    sb.push_back(mk(2, 1'b0));
    sb.push_back(mk(-1, 1'b0));
`else
    sb.push_back(mk(1, 1'b0));
    sb.push_back(mk(-2, 1'b0));
`endif
    send(6);
    send(-6);
    wait_drain("rounding");
  endtask

  task automatic test_saturation();
    num_acc = 8'd1;
    shift   = 6'd0;
    sb.push_back(mk(127, 1'b1));
    sb.push_back(mk(-128, 1'b1));
    sb.push_back(mk(-128, 1'b0));
    sb.push_back(mk(127, 1'b0));
    send(1000);
    send(-1000);
    send(-128);
    send(127);
    wait_drain("saturation");
  endtask

  task automatic test_backpressure();
    num_acc   = 8'd1;
    shift     = 6'd0;
    ready_out = 1'b0;
    sb.push_back(mk(5, 1'b0));
    send(5);
    valid_in = 1'b1;
    D_in     = 32'd77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_tests++;
      if (valid_out !== 1'b1 || ready_in !== 1'b0 || Q_out !== 8'd5) begin
        n_fail++;
        $display("FAIL backpressure_hold: valid_out=%0b ready_in=%0b Q_out=%0d, required 1 0 5",
                 valid_out, ready_in, $signed(Q_out));
      end
    end
    // The held 77 must start a fresh group once the stalled result leaves.
    sb.push_back(mk(77, 1'b0));
    @(posedge clk_i);
    #1;
    ready_out = 1'b1;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    n_tests++;
    if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: ready_in=%0b valid_out=%0b, required 1 0",
               ready_in, valid_out);
    end
    @(posedge clk_i);
    #1;
    valid_in = 1'b0;
    wait_drain("backpressure");
  endtask

  task automatic test_reset_mid_group();
    num_acc = 8'd4;
    shift   = 6'd0;
    send(100);
    send(100);
    rst_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (ready_in !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ready: ready_in=%0b, required 0", ready_in);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb.push_back(mk(4, 1'b0));
    for (int i = 0; i < 4; i++) send(1);
    wait_drain("reset_mid_group");
  endtask

  task automatic test_config_change();
    num_acc = 8'd3;
    shift   = 6'd1;
    sb.push_back(mk(12, 1'b0));
    send(8);
    num_acc = 8'd1;
    shift   = 6'd3;
    send(8);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL config_change_early: valid_out=%0b after beat 2, required 0", valid_out);
    end
    send(8);
    wait_drain("config_change");
  endtask

  task automatic test_back_to_back();
    int t0;
    int d;
    int sh;
    num_acc = 8'd0;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      d  = $urandom_range(4000) - 2000;
      sh = $urandom_range(7);
      shift = 6'(sh);
      sb.push_back(ref_requant(longint'(d), sh));
      send(d);
    end
    n_tests++;
    if (cyc - t0 != 31) begin
      n_fail++;
      $display("FAIL back_to_back_rate: 16 single-beat groups took %0d cycles, required 31", cyc - t0);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_random_groups();
    longint s;
    int     n;
    int     sh;
    int     d;
    for (int g = 0; g < 6; g++) begin
      n  = $urandom_range(5, 2);
      sh = (g == 5) ? 50 : $urandom_range(9);
      num_acc = 8'(n);
      shift   = 6'(sh);
      s = 0;
      for (int i = 0; i < n; i++) begin
        d = $urandom_range(200000) - 100000;
        s = s + d;
        if (i == n - 1) sb.push_back(ref_requant(s, sh));
        send(d);
        shift = 6'($urandom_range(63));
      end
    end
    wait_drain("random_groups");
  endtask

  initial begin
    rst_i     = 1'b1;
    D_in      = '0;
    valid_in  = 1'b0;
    num_acc   = 8'd1;
    shift     = 6'd0;
    ready_out = 1'b1;
    test_reset();
    test_group_sum();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_mid_group();
    test_config_change();
    test_back_to_back();
    test_random_groups();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_requant.md
ACCUM_REQUANT -- requirements
Module: accum_requant

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, width of signed partial result D_in from seq_mult_adder.
REQ-002 SHALL have parameter ACC_WIDTH, default 40, width of the internal signed accumulator (ACC_WIDTH >= IN_WIDTH).
REQ-003 SHALL have parameter OUT_WIDTH, default 8, width of the signed requantized output.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, width of the group-length input.
REQ-005 SHALL have ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous reset, active-high.
- D_in  in  IN_WIDTH  signed partial result.
- valid_in  in  1  D_in valid.
- ready_in  out  1  block accepts D_in.
- num_acc  in  CNT_WIDTH  beats per output group; 0 treated as 1.
- shift  in  6  arithmetic right-shift amount.
- Q_out  out  OUT_WIDTH  signed requantized result.
- sat_o  out  1  Q_out was clipped.
- valid_out  out  1  Q_out valid.
- ready_out  in  1  consumer accepts Q_out.

Function
REQ-006 SHALL implement two states: ACC (ready_in=1, valid_out=0) and HOLD (ready_in=0, valid_out=1).
REQ-007 Input beat SHALL occur on rising clk_i with valid_in=1 and ready_in=1; otherwise the accumulator and counter hold.
REQ-008 On the first beat of a group (cnt=0), num_acc and shift SHALL be latched and held for the whole group; changes mid-group SHALL be ignored.
REQ-009 Each beat SHALL add sign-extended D_in to acc; acc SHALL wrap modulo 2^ACC_WIDTH, with no overflow detection.
REQ-010 On the beat where cnt equals latched num_acc-1, the block SHALL:
- register requant(acc + D_in) into Q_out and sat_o;
- move to HOLD;
- valid_out SHALL rise the cycle after that beat (latency 1).
REQ-011 requant(x) SHALL be:
- optional rounding per REQ-018;
- arithmetic right shift by min(shift, ACC_WIDTH-1);
- saturation to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1];
- sat_o=1 when the saturation step changed the value.
REQ-012 In HOLD, Q_out, sat_o and valid_out SHALL stay stable while ready_out=0 (backpressure of any length).
REQ-013 In HOLD with ready_out=1, the block SHALL at that edge:
- complete the output transfer;
- clear acc and cnt;
- return to ACC.
ready_in SHALL be 1 in the next cycle. valid_in in a HOLD cycle is never consumed.
REQ-014 With latched num_acc=1 (or 0), every accepted beat SHALL produce one output, giving throughput of one result per 2 cycles.

Reset
REQ-015 While rst_i=1 at a rising edge, the block SHALL set:
- state to ACC; acc, cnt, Q_out, sat_o to 0; valid_out to 0;
- ready_in to 0 for the cycle rst_i is high, then 1.
REQ-016 Reset asserted mid-group or in HOLD SHALL discard the partial accumulation or pending output; no output is emitted for that group.

Configuration
REQ-017 Macro ACCUM_REQUANT_ROUND_EN SHALL select the rounding mode.
REQ-018 With the macro defined, requant SHALL add 2^(shift-1) before shifting when shift>0 (round-half-up); without it, requant SHALL truncate toward minus infinity (plain arithmetic shift). shift=0 SHALL be identical in both builds.

Verification
REQ-019 Group sum, default params: num_acc=4, shift=2, D_in=10,20,30,40 back-to-back, ready_out=1 -> single output Q_out=25, sat_o=0, valid_out one cycle after the 4th beat.
REQ-020 Rounding: num_acc=1, shift=2.
- D_in=6 -> Q_out=2 with macro, 1 without.
- D_in=-6 -> Q_out=-1 with macro, -2 without.
REQ-021 Saturation: num_acc=1, shift=0.
- D_in=1000 -> Q_out=127, sat_o=1.
- D_in=-1000 -> Q_out=-128, sat_o=1.
- D_in=-128 -> Q_out=-128, sat_o=0.
REQ-022 Backpressure: hold ready_out=0 for 3 cycles in HOLD with valid_in=1 -> Q_out stable, ready_in=0, no beat consumed; after ready_out=1, the next group starts from acc=0.
REQ-023 Reset mid-group: num_acc=4; after 2 beats of 100, pulse rst_i one cycle; then 4 beats of 1, shift=0 -> Q_out=4, with no output for the aborted group.
REQ-024 Mid-group config change: num_acc=3 latched; change num_acc to 1 and shift to 3 after beat 1 -> output still after 3 beats, using shift latched at beat 1.
